// File: rtl/mismatch_checker_pkg.sv
// Shared types and helpers for the mismatch checker and its counters.
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  localparam int unsigned DEFAULT_CNT_W = 16;

  // Largest value representable by a w-bit counter (2^w - 1).
  function automatic longint unsigned max_count(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/mismatch_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import checker_pkg::*;
#(
  parameter int unsigned W = DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count register: clear has priority, increment stops at all-ones.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mismatch_checker.sv
// Compares reference/DUT vector pairs one sample per clock and keeps run
// statistics: sample count, error count, first error index and a sticky
// per-bit mismatch mask. A run ends after NUM_SAMPLES accepted samples.
module mismatch_checker
  import checker_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned NUM_SAMPLES = 100
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] ref_vec,
  input  logic [WIDTH-1:0] dut_vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] err_mask
);

  if ((NUM_SAMPLES < 1) || (64'(NUM_SAMPLES) > max_count(CNT_W))) begin : g_bad_num_samples
    $error("mismatch_checker: NUM_SAMPLES must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  chk_state_t state;
  chk_state_t state_next;

  logic             launch;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] diff;
  logic             mismatch;

  assign launch   = start && ((state == IDLE) || (state == DONE));
  assign accept   = (state == RUN) && sample_valid;
  assign diff     = ref_vec ^ dut_vec;
  assign mismatch = |diff;
  // samples still holds the pre-increment value on the accepting edge.
  assign last     = accept && (samples == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start only honoured outside RUN; final sample ends the run.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    pass = done && (errors == '0);
  end

  sat_counter #(.W(CNT_W)) u_samples (
    .clk      (clk),
    .areset_n (areset_n),
    .clr      (launch),
    .inc      (accept),
    .q        (samples)
  );

  sat_counter #(.W(CNT_W)) u_errors (
    .clk      (clk),
    .areset_n (areset_n),
    .clr      (launch),
    .inc      (accept && mismatch),
    .q        (errors)
  );

  // First-error capture and sticky per-bit mismatch mask.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      err_mask        <= '0;
    end else if (launch) begin
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      err_mask        <= '0;
    end else if (accept) begin
      err_mask <= err_mask | diff;
      if (mismatch && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_idx   <= samples;
      end
    end
  end

endmodule
